ram_bus_arbiter: RTL
====================

// Module: ram_bus_arbiter
// PURPOSE
//  Shares the single external 16-bit SRAM between the instruction-fetch port (IF) and the data-memory port (MEM).
//  Sequences every SRAM access (strobes, address/data hold, read capture) and returns a one-cycle done pulse to the winner.
//  Sits between the pipeline memory controllers and the SRAM pins. Replaces per-port RAM handshaking with one central owner.
// PARAMETERS
//  ACCESS_CYCLES  3   SRAM access length in clk cycles; legal range 3..15.
//  STARVE_LIMIT   4   consecutive IF losses after which IF wins the next arbitration; legal range 1..15.
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   synchronous reset, active-low
//  inst_req     in   1   IF read request; held with inst_addr until inst_done
//  inst_addr    in   16  IF word address
//  inst_data    out  16  fetched instruction; valid while inst_done=1
//  inst_done    out  1   one-cycle completion pulse for IF
//  data_req     in   1   MEM request; held with data_we/addr/wdata until data_done
//  data_we      in   1   1=write, 0=read
//  data_addr    in   16  MEM word address
//  data_wdata   in   16  MEM write data
//  data_rdata   out  16  MEM read data; valid while data_done=1
//  data_done    out  1   one-cycle completion pulse for MEM
//  ram_addr     out  16  SRAM address
//  ram_wdata    out  16  SRAM write data, driven to the pad tristate elsewhere
//  ram_rdata    in   16  SRAM read data from the pad
//  ram_ce_n     out  1   chip enable, active-low
//  ram_oe_n     out  1   output enable, active-low
//  ram_we_n     out  1   write enable, active-low
// BEHAVIOUR
//  States: IDLE -> ACCESS (ACCESS_CYCLES cycles, counter k=0..N-1) -> DONE (1 cycle) -> IDLE.
//  Reset (rst=0 at edge): state=IDLE. ram_ce_n/oe_n/we_n=1. ram_addr, ram_wdata, inst_data, data_rdata=0.
//   inst_done=data_done=0. Starve counter=0. Any in-flight access is aborted; no done pulse is issued for it.
//  IDLE: sample requests each edge. If both are high, MEM wins unless starve counter==STARVE_LIMIT, in which case IF wins.
//   If neither is high, remain in IDLE with all strobes high.
//  Starve counter: +1 (saturating) whenever IF loses to MEM. Cleared on an IF grant.
//  Grant: latch owner, we, addr (and wdata) into registers. Requester inputs are ignored until DONE.
//  ACCESS:
//   - ram_ce_n=0. ram_addr and ram_wdata are stable for all k.
//   - Read: ram_oe_n=0 and ram_we_n=1 for all k. ram_rdata is captured at the edge ending k=N-1.
//   - Write: ram_oe_n=1. ram_we_n=0 only for k=1..N-2, giving a full cycle of address setup and hold around the pulse.
//  DONE: strobes high. The owner's done pulse =1 for exactly this cycle, with captured data on inst_data/data_rdata.
//   A write returns data_rdata unchanged. The non-owner's done stays 0. Next state is IDLE.
//  Latency: grant edge to done pulse = ACCESS_CYCLES+1 cycles. Minimum spacing between back-to-back grants is ACCESS_CYCLES+2 cycles.
//  A request still high in the IDLE cycle after DONE is a new request. The requester drops or changes it on seeing done.
//  inst_data/data_rdata hold their last value outside DONE.
//  IF requests never write. inst_addr/data_addr changes during ACCESS do not affect the bus.
// CONFIGURATION
//  RAM_ARB_LAST_INST_EN defined:
//   - Keeps a last-fetch register {valid, addr, data}, loaded at the IF DONE.
//   - In IDLE, with inst_req=1, data_req=0, valid=1 and inst_addr==stored addr: go to DONE directly.
//     inst_done pulses the next cycle with the stored data, no SRAM strobes, 1-cycle latency.
//   - A MEM write whose address equals the stored addr clears valid at its grant. Reset clears valid.
//  Not defined: no such register. Every IF request performs a full SRAM access.
// TESTING
//  1. rst=0 for 2 cycles during a write at k=1 -> ram_we_n=1 next cycle, no data_done, state IDLE, all outputs at reset values.
//  2. MEM write addr 16'h0040 data 16'hBEEF, N=3 -> ce_n low 3 cycles, we_n low only at k=1, data_done at grant+4.
//     Then read 16'h0040 -> data_rdata=16'hBEEF with data_done.
//  3. IF read 16'h0000, ram_rdata=16'h0800 -> oe_n low 3 cycles, inst_done with inst_data=16'h0800 at grant+4, data_done=0.
//  4. inst_req and data_req held high continuously, STARVE_LIMIT=4 -> grant pattern M,M,M,M,I,M,M,M,M,I.
//  5. With RAM_ARB_LAST_INST_EN: fetch 16'h0010 twice -> second inst_done one cycle after request, no strobe activity.
//     Write 16'h0010, then fetch -> full SRAM access again.
//  6. Request dropped mid-ACCESS -> access completes and the done pulse is still issued; the next IDLE sees no request.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// Two-port arbiter (instruction fetch vs. data memory) for one external 16-bit SRAM.
// Optional last-fetch bypass register is enabled by defining RAM_ARB_LAST_INST_EN.
module ram_bus_arbiter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [15:0] inst_addr,
  output logic [15:0] inst_data,
  output logic        inst_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_wdata,
  output logic [15:0] data_rdata,
  output logic        data_done,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST_K     = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_reg;
  logic [3:0]  k_reg;
  logic [3:0]  starve_reg;
  logic        owner_inst_reg;
  logic        we_reg;
  logic [3:0]  k_next;
  logic        any_req;
  logic        grant_inst;
  logic        hit;
  logic [15:0] hit_data;

  assign k_next     = k_reg + 4'd1;
  assign any_req    = inst_req | data_req;
  assign grant_inst = inst_req & (~data_req | (starve_reg == STARVE_MAX));

`ifdef RAM_ARB_LAST_INST_EN
  logic        lf_valid_reg;
  logic [15:0] lf_addr_reg;
  logic [15:0] lf_data_reg;

  assign hit      = inst_req & ~data_req & lf_valid_reg & (inst_addr == lf_addr_reg);
  assign hit_data = lf_data_reg;

  // Loaded as an SRAM fetch completes; a MEM write to the same word invalidates at its grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lf_valid_reg <= 1'b0;
      lf_addr_reg  <= '0;
      lf_data_reg  <= '0;
    end else if (state_reg == ACCESS && k_reg == LAST_K && owner_inst_reg) begin
      lf_valid_reg <= 1'b1;
      lf_addr_reg  <= ram_addr;
      lf_data_reg  <= ram_rdata;
    end else if (state_reg == IDLE && !hit && any_req && !grant_inst && data_we &&
                 data_addr == lf_addr_reg) begin
      lf_valid_reg <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      starve_reg     <= '0;
      owner_inst_reg <= 1'b0;
      we_reg         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_ce_n       <= 1'b1;
      ram_oe_n       <= 1'b1;
      ram_we_n       <= 1'b1;
      inst_data      <= '0;
      data_rdata     <= '0;
      inst_done      <= 1'b0;
      data_done      <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hit) begin
            state_reg  <= DONE;
            inst_done  <= 1'b1;
            inst_data  <= hit_data;
            starve_reg <= '0;
          end else if (any_req) begin
            state_reg      <= ACCESS;
            k_reg          <= '0;
            owner_inst_reg <= grant_inst;
            we_reg         <= ~grant_inst & data_we;
            ram_addr       <= grant_inst ? inst_addr : data_addr;
            if (!grant_inst)
              ram_wdata <= data_wdata;
            ram_ce_n <= 1'b0;
            ram_oe_n <= ~grant_inst & data_we;
            ram_we_n <= 1'b1;
            if (grant_inst)
              starve_reg <= '0;
            else if (inst_req && starve_reg != 4'hF)
              starve_reg <= starve_reg + 4'd1;
          end
        end
        ACCESS: begin
          if (k_reg == LAST_K) begin
            state_reg <= DONE;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            if (owner_inst_reg) begin
              inst_done <= 1'b1;
              inst_data <= ram_rdata;
            end else begin
              data_done <= 1'b1;
              if (!we_reg)
                data_rdata <= ram_rdata;
            end
          end else begin
            k_reg <= k_next;
            // Write strobe covers k=1..N-2 only, leaving a setup and a hold cycle.
            ram_we_n <= ~(we_reg & (k_next < LAST_K));
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
